// File: rtl/bit_unstuff_rx.sv
// Receive-side bit unstuffer: optional NRZI decode, removal of the stuffed zero after RUN_LEN
// ones, stuffing-violation detection and LSB-first assembly of DATA_W-bit words.
module bit_unstuff_rx #(
  parameter int unsigned RUN_LEN     = 6,
  parameter int unsigned DATA_W      = 8,
  parameter bit          NRZI_DECODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_unstuff,
  input  logic              in_valid,
  input  logic              data_in,
  input  logic              sync_clr,
  output logic              out_bit,
  output logic              out_valid,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              stuff_err
);

  localparam int unsigned CntW = $clog2(RUN_LEN + 1);
  localparam int unsigned BitW = $clog2(DATA_W);

  logic [CntW-1:0]   ones_q, ones_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shreg_shifted;
  logic              prev_q, prev_d;
  logic              out_bit_q, out_bit_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              stuff_err_q, stuff_err_d;
  logic              dec_bit;
  logic              stuff_slot;

  // NRZI: no transition on the line means a 1
  assign dec_bit       = NRZI_DECODE ? ~(data_in ^ prev_q) : data_in;
  assign stuff_slot    = en_unstuff && (ones_q == CntW'(RUN_LEN));
  assign shreg_shifted = {dec_bit, shreg_q[DATA_W-1:1]};

  always_comb begin
    ones_d       = ones_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    prev_d       = prev_q;
    out_bit_d    = out_bit_q;
    out_valid_d  = 1'b0;
    word_d       = word_q;
    word_valid_d = 1'b0;
    stuff_err_d  = 1'b0;
    if (sync_clr) begin
      ones_d  = '0;
      bit_d   = '0;
      shreg_d = '0;
      prev_d  = 1'b1;
    end else if (in_valid) begin
      prev_d = data_in;
      if (stuff_slot) begin
        ones_d = '0;
        // A 1 where the stuffed zero belongs corrupts the word in progress
        if (dec_bit) begin
          stuff_err_d = 1'b1;
          bit_d       = '0;
          shreg_d     = '0;
        end
      end else begin
        out_valid_d = 1'b1;
        out_bit_d   = dec_bit;
        ones_d      = (en_unstuff && dec_bit) ? ones_q + CntW'(1) : '0;
        shreg_d     = shreg_shifted;
        if (bit_q == BitW'(DATA_W - 1)) begin
          bit_d        = '0;
          word_d       = shreg_shifted;
          word_valid_d = 1'b1;
        end else begin
          bit_d = bit_q + BitW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      prev_q       <= 1'b1;
      out_bit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      ones_q       <= ones_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      prev_q       <= prev_d;
      out_bit_q    <= out_bit_d;
      out_valid_q  <= out_valid_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      stuff_err_q  <= stuff_err_d;
    end
  end

  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_bit_unstuff_rx.sv
// Bench for bit_unstuff_rx: three instances (6/8 plain, 3/4 plain, 6/8 NRZI) on shared stimulus,
// checked against a bit-level reference model, a vector table and hand-written corner sequences.
module tb_bit_unstuff_rx;

  logic clk = 1'b0;
  logic rst, en_unstuff, in_valid, data_in, sync_clr;

  logic       ov0, ob0, wv0, se0, ov1, ob1, wv1, se1, ov2, ob2, wv2, se2;
  logic [7:0] wo0, wo2;
  logic [3:0] wo1;

  logic        ov_a[3], ob_a[3], wv_a[3], se_a[3];
  logic [31:0] wo_a[3];

  bit_unstuff_rx #(.RUN_LEN(6), .DATA_W(8), .NRZI_DECODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en_unstuff(en_unstuff), .in_valid(in_valid), .data_in(data_in),
    .sync_clr(sync_clr), .out_bit(ob0), .out_valid(ov0), .word_out(wo0), .word_valid(wv0),
    .stuff_err(se0));
  bit_unstuff_rx #(.RUN_LEN(3), .DATA_W(4), .NRZI_DECODE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en_unstuff(en_unstuff), .in_valid(in_valid), .data_in(data_in),
    .sync_clr(sync_clr), .out_bit(ob1), .out_valid(ov1), .word_out(wo1), .word_valid(wv1),
    .stuff_err(se1));
  bit_unstuff_rx #(.RUN_LEN(6), .DATA_W(8), .NRZI_DECODE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en_unstuff(en_unstuff), .in_valid(in_valid), .data_in(data_in),
    .sync_clr(sync_clr), .out_bit(ob2), .out_valid(ov2), .word_out(wo2), .word_valid(wv2),
    .stuff_err(se2));

  assign ov_a[0] = ov0; assign ob_a[0] = ob0; assign wv_a[0] = wv0; assign se_a[0] = se0;
  assign ov_a[1] = ov1; assign ob_a[1] = ob1; assign wv_a[1] = wv1; assign se_a[1] = se1;
  assign ov_a[2] = ov2; assign ob_a[2] = ob2; assign wv_a[2] = wv2; assign se_a[2] = se2;
  assign wo_a[0] = {24'd0, wo0};
  assign wo_a[1] = {28'd0, wo1};
  assign wo_a[2] = {24'd0, wo2};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int rl_a[3] = '{6, 3, 6};
  int dw_a[3] = '{8, 4, 8};
  bit nz_a[3] = '{1'b0, 1'b0, 1'b1};

  // Reference model state: run of delivered ones, bits collected so far and their value
  int          m_run[3];
  int          m_cnt[3];
  logic [31:0] m_acc[3];
  bit          m_prev[3];
  bit          e_ov[3], e_ob[3], e_wv[3], e_se[3];
  logic [31:0] e_wo[3];

  typedef struct {
    bit iv; bit di; bit en; bit sc;
    bit e_ov; bit e_ob; bit e_wv; bit e_se; logic [7:0] e_wo;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_cnt[i] = 0; m_acc[i] = '0; m_prev[i] = 1'b1;
      e_ov[i] = 0; e_ob[i] = 0; e_wv[i] = 0; e_se[i] = 0; e_wo[i] = '0;
    end
  endtask

  task automatic model(input int i, input bit iv, input bit di, input bit en, input bit sc);
    bit d;
    e_ov[i] = 0; e_wv[i] = 0; e_se[i] = 0;
    if (sc) begin
      m_run[i] = 0; m_cnt[i] = 0; m_acc[i] = '0; m_prev[i] = 1'b1;
    end else if (iv) begin
      d = nz_a[i] ? (di == m_prev[i]) : di;
      m_prev[i] = di;
      if (en && m_run[i] == rl_a[i]) begin
        m_run[i] = 0;
        if (d) begin
          e_se[i] = 1; m_cnt[i] = 0; m_acc[i] = '0;
        end
      end else begin
        e_ov[i] = 1;
        e_ob[i] = d;
        m_run[i] = (en && d) ? m_run[i] + 1 : 0;
        if (d) m_acc[i] = m_acc[i] | (32'd1 << m_cnt[i]);
        m_cnt[i]++;
        if (m_cnt[i] == dw_a[i]) begin
          e_wo[i] = m_acc[i]; e_wv[i] = 1; m_cnt[i] = 0; m_acc[i] = '0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d out_valid", i), {31'd0, ov_a[i]}, {31'd0, e_ov[i]});
      if (e_ov[i]) chk($sformatf("i%0d out_bit", i), {31'd0, ob_a[i]}, {31'd0, e_ob[i]});
      chk($sformatf("i%0d word_valid", i), {31'd0, wv_a[i]}, {31'd0, e_wv[i]});
      chk($sformatf("i%0d stuff_err", i), {31'd0, se_a[i]}, {31'd0, e_se[i]});
      chk($sformatf("i%0d word_out", i), wo_a[i], e_wo[i]);
    end
  endtask

  // Called at 1 time unit after a rising edge; outputs are sampled 1 unit after the next edge
  task automatic step(input bit iv, input bit di, input bit en, input bit sc);
    in_valid = iv; data_in = di; en_unstuff = en; sync_clr = sc;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) model(i, iv, di, en, sc);
    check_all();
  endtask

  task automatic do_reset();
    in_valid = 0; data_in = 0; en_unstuff = 1; sync_clr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    check_all();
  endtask

  task automatic add(input bit iv, input bit di, input bit en, input bit sc, input bit eov,
                     input bit eob, input bit ewv, input bit ese, input logic [7:0] ewo);
    vec_t v;
    v.iv = iv; v.di = di; v.en = en; v.sc = sc;
    v.e_ov = eov; v.e_ob = eob; v.e_wv = ewv; v.e_se = ese; v.e_wo = ewo;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1; in_valid = 0; data_in = 0; en_unstuff = 1; sync_clr = 0;

    // Stuffed zero removed, word FD on the 8th delivered bit
    add(1, 1, 1, 0, 1, 1, 0, 0, 8'h00);
    add(1, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) add(1, 1, 1, 0, 1, 1, 0, 0, 8'h00);
    add(1, 1, 1, 0, 1, 1, 1, 0, 8'hFD);
    add(1, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    add(1, 1, 1, 0, 1, 1, 0, 0, 8'h00);
    add(1, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    // Stuffing violation discards the partial word; a gap leaves state alone
    add(1, 1, 1, 1, 0, 0, 0, 0, 8'h00);
    add(1, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    add(1, 1, 1, 0, 1, 1, 0, 0, 8'h00);
    add(0, 1, 1, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) add(1, 1, 1, 0, 1, 1, 0, 0, 8'h00);
    add(1, 1, 1, 0, 1, 1, 1, 0, 8'hFA);
    add(1, 1, 1, 0, 1, 1, 0, 0, 8'h00);
    add(1, 1, 1, 0, 0, 0, 0, 1, 8'h00);
    for (int k = 0; k < 7; k++) add(1, k[0], 1, 0, 1, k[0], 0, 0, 8'h00);
    add(1, 1, 1, 0, 1, 1, 1, 0, 8'hAA);
    // Unstuffing disabled: every bit delivered
    add(1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(1, 1, 0, 0, 1, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) add(1, 1, 0, 0, 1, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 1, 1, 1, 0, 8'hFD);
    add(1, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    add(1, 1, 0, 0, 1, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 1, 0, 0, 0, 8'h00);

    do_reset();
    foreach (tbl[n]) begin
      step(tbl[n].iv, tbl[n].di, tbl[n].en, tbl[n].sc);
      chk($sformatf("tbl%0d out_valid", n), {31'd0, ov0}, {31'd0, tbl[n].e_ov});
      if (tbl[n].e_ov) chk($sformatf("tbl%0d out_bit", n), {31'd0, ob0}, {31'd0, tbl[n].e_ob});
      chk($sformatf("tbl%0d word_valid", n), {31'd0, wv0}, {31'd0, tbl[n].e_wv});
      chk($sformatf("tbl%0d stuff_err", n), {31'd0, se0}, {31'd0, tbl[n].e_se});
      if (tbl[n].e_wv) chk($sformatf("tbl%0d word_out", n), {24'd0, wo0}, {24'd0, tbl[n].e_wo});
    end

    // NRZI decode on instance 2: line 1,1,0,1 -> 1,1,0,0
    do_reset();
    step(1, 1, 1, 0); chk("nrzi b0", {31'd0, ob2}, 32'd1);
    step(1, 1, 1, 0); chk("nrzi b1", {31'd0, ob2}, 32'd1);
    step(1, 0, 1, 0); chk("nrzi b2", {31'd0, ob2}, 32'd0);
    step(1, 1, 1, 0); chk("nrzi b3", {31'd0, ob2}, 32'd0);
    chk("nrzi valid", {31'd0, ov2}, 32'd1);

    // Short run length / narrow word on instance 1, then sync_clr mid-word
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 0); chk("rl3 one", {31'd0, ov1}, 32'd1);
    end
    step(1, 0, 1, 0); chk("rl3 drop", {31'd0, ov1}, 32'd0);
    step(1, 1, 1, 0); chk("rl3 word_valid", {31'd0, wv1}, 32'd1);
    chk("rl3 word_out", {28'd0, wo1}, 32'hF);
    step(1, 1, 1, 1);
    step(1, 0, 1, 0); step(1, 1, 1, 0); chk("rl3 pre-clr", {31'd0, wv1}, 32'd0);
    step(1, 1, 1, 1); chk("rl3 clr keeps word", {28'd0, wo1}, 32'hF);
    for (int k = 0; k < 3; k++) begin
      step(1, k[0], 1, 0); chk("rl3 post-clr", {31'd0, wv1}, 32'd0);
    end
    step(1, 1, 1, 0); chk("rl3 word2 valid", {31'd0, wv1}, 32'd1);
    chk("rl3 word2", {28'd0, wo1}, 32'hA);

    // Asynchronous reset mid-run
    step(1, 1, 1, 1);
    for (int k = 0; k < 5; k++) step(1, 1, 1, 0);
    #2 rst = 1;
    #1;
    chk("arst out_valid", {31'd0, ov0}, 32'd0);
    chk("arst out_bit", {31'd0, ob0}, 32'd0);
    chk("arst word_out", {24'd0, wo0}, 32'd0);
    chk("arst word_out i1", {28'd0, wo1}, 32'd0);
    in_valid = 0;
    @(posedge clk); #1 rst = 0;
    model_reset();
    for (int k = 0; k < 6; k++) step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    chk("arst drop", {31'd0, ov0}, 32'd0);
    chk("arst no err", {31'd0, se0}, 32'd0);

    // Randomised traffic, ones-heavy to reach the stuff slot often
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 49) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
